// File: rtl/encoder_pkg.sv
// Shared types and constants for the instruction encoder: op classes, FSM states,
// captured request record, and the condition/opcode values the encoder recognises.
package encoder_pkg;

  typedef enum logic [1:0] {
    OP_DP  = 2'b00,
    OP_MEM = 2'b01,
    OP_BR  = 2'b10,
    OP_ILL = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ENC   = 2'd1,
    WRITE = 2'd2
  } state_t;

  localparam logic [3:0] COND_AL = 4'hE;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_MOV = 4'b1101;

  typedef struct packed {
    op_t         op;
    logic [3:0]  cond;
    logic [3:0]  cmd;
    logic        imm;
    logic        sl;
    logic [3:0]  rn;
    logic [3:0]  rd;
    logic [11:0] src2;
    logic [23:0] imm24;
  } req_t;

endpackage

// File: rtl/instr_encoder_if.sv
// Request, instruction-memory write and status signals of the encoder.
// slave = encoder side, master = requester / memory / observer side.
interface instr_encoder_if #(
  parameter int ADDR_W = 6
);
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        in_op;
  logic [3:0]        in_cond;
  logic [3:0]        in_cmd;
  logic              in_imm;
  logic              in_sl;
  logic [3:0]        in_rn;
  logic [3:0]        in_rd;
  logic [11:0]       in_src2;
  logic [23:0]       in_imm24;
  logic              flush;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              full;
  logic              err;
  logic [7:0]        err_cnt;

  modport slave (
    input  in_valid, in_op, in_cond, in_cmd, in_imm, in_sl, in_rn, in_rd,
           in_src2, in_imm24, flush,
    output in_ready, mem_we, mem_addr, mem_wdata, full, err, err_cnt
  );

  modport master (
    output in_valid, in_op, in_cond, in_cmd, in_imm, in_sl, in_rn, in_rd,
           in_src2, in_imm24, flush,
    input  in_ready, mem_we, mem_addr, mem_wdata, full, err, err_cnt
  );
endinterface

// File: rtl/instr_word_build.sv
// Combinational assembly of a 32-bit instruction word from a captured request.
// No state, no handshake; legal is low only for the reserved op class.
module instr_word_build
  import encoder_pkg::*;
(
  input  req_t        req,
  output logic [31:0] word,
  output logic        legal
);

  logic       s_bit;
  logic [3:0] rd_fld;

  always_comb begin
    word   = 32'd0;
    legal  = 1'b1;
    s_bit  = req.sl;
    rd_fld = req.rd;
    unique case (req.op)
      OP_DP: begin
        // Compare-class opcodes only set flags: S is implied and Rd is unused.
        if (req.cmd[3:2] == CMD_CMP[3:2]) begin
          s_bit  = 1'b1;
          rd_fld = 4'd0;
        end
        word = {req.cond, 2'b00, req.imm, req.cmd, s_bit, req.rn, rd_fld, req.src2};
      end
      OP_MEM: begin
        // Memory form flips the immediate sense; pre-indexed, add, word, no writeback.
        word = {req.cond, 2'b01, ~req.imm, 1'b1, 1'b1, 1'b0, 1'b0, req.sl,
                req.rn, req.rd, req.src2};
      end
      OP_BR: begin
        word = {req.cond, 3'b101, 1'b0, req.imm24};
      end
      OP_ILL: begin
        legal = 1'b0;
      end
      default: begin
        legal = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Accepts one request, encodes it, and writes the word to sequential memory addresses;
// write appears two cycles after acceptance; in_ready low while busy, full or flushing.
// Define INSTR_ENCODER_ERRCNT_EN to enable the saturating illegal-request counter.
module instr_encoder #(
  parameter int ADDR_W    = 6,
  parameter int BASE_ADDR = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  instr_encoder_if.slave   bus
);
  import encoder_pkg::*;

  localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

  state_t            state_q, state_d;
  req_t              req_q, req_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              full_q, full_d;
  logic              we_q, we_d;
  logic [31:0]       wdata_q, wdata_d;

  logic [31:0]       word;
  logic              legal;
  logic              in_ready;
  logic              accept;
  logic              err_w;

  instr_word_build u_build (
    .req   (req_q),
    .word  (word),
    .legal (legal)
  );

  assign in_ready = (state_q == IDLE) && !full_q && !bus.flush;
  assign accept   = bus.in_valid && in_ready;
  assign err_w    = (state_q == ENC) && !legal;

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    addr_d  = addr_q;
    full_d  = full_q;
    we_d    = 1'b0;
    wdata_d = wdata_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d     = ENC;
          req_d.op    = op_t'(bus.in_op);
          req_d.cond  = bus.in_cond;
          req_d.cmd   = bus.in_cmd;
          req_d.imm   = bus.in_imm;
          req_d.sl    = bus.in_sl;
          req_d.rn    = bus.in_rn;
          req_d.rd    = bus.in_rd;
          req_d.src2  = bus.in_src2;
          req_d.imm24 = bus.in_imm24;
        end
      end
      ENC: begin
        if (legal) begin
          state_d = WRITE;
          we_d    = 1'b1;
          wdata_d = word;
        end else begin
          state_d = IDLE;
        end
      end
      WRITE: begin
        state_d = IDLE;
        addr_d  = addr_q + 1'b1;
        if (addr_q == ADDR_MAX) begin
          full_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // Flush overrides the post-write increment, so an in-flight write still lands first.
    if (bus.flush) begin
      addr_d = BASE;
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      req_q   <= '0;
      addr_q  <= BASE;
      full_q  <= 1'b0;
      we_q    <= 1'b0;
      wdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      full_q  <= full_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
    end
  end

`ifdef INSTR_ENCODER_ERRCNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_w && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_cnt_q <= 8'd0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign bus.err_cnt = err_cnt_q;
`else
  assign bus.err_cnt = 8'd0;
`endif

  assign bus.in_ready  = in_ready;
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.full      = full_q;
  assign bus.err       = err_w;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder (ADDR_W=2): expected writes are queued at acceptance
// and popped by a monitor that compares address, data and timing of every mem_we pulse.
module tb_instr_encoder;

  typedef struct {
    logic [1:0]  addr;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  logic clk;
  logic reset_n;
  int   n_chk;
  int   n_pass;
  int   cyc;
  logic [1:0] exp_addr;
  logic prev_we;
  logic [7:0] exp_errcnt;
  exp_t sb[$];

  instr_encoder_if #(.ADDR_W(2)) bus ();

  instr_encoder #(.ADDR_W(2), .BASE_ADDR(0)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Scoreboard consumer: every write must match the oldest queued expectation.
  initial prev_we = 1'b0;
  always @(negedge clk) begin
    if (reset_n === 1'b1 && bus.mem_we === 1'b1) begin
      chk("we_width", {31'd0, prev_we}, 32'd0);
      if (sb.size() == 0) begin
        chk("write_expected", {31'd0, bus.mem_we}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("wr_addr", {30'd0, bus.mem_addr}, {30'd0, e.addr});
        chk("wr_data", bus.mem_wdata, e.data);
        chk("wr_cycle", cyc, e.cyc);
      end
    end
    prev_we = bus.mem_we;
  end

  task automatic scramble();
    bus.in_op    = 2'($urandom);
    bus.in_cond  = 4'($urandom);
    bus.in_cmd   = 4'($urandom);
    bus.in_imm   = 1'($urandom);
    bus.in_sl    = 1'($urandom);
    bus.in_rn    = 4'($urandom);
    bus.in_rd    = 4'($urandom);
    bus.in_src2  = 12'($urandom);
    bus.in_imm24 = 24'($urandom);
  endtask

  task automatic send(input logic [1:0] op, input logic [3:0] cond, input logic [3:0] cmd,
                      input logic imm, input logic sl, input logic [3:0] rn,
                      input logic [3:0] rd, input logic [11:0] src2,
                      input logic [23:0] imm24, input logic [31:0] word, input bit flush_w);
    int n;
    n = 0;
    @(negedge clk);
    while (bus.in_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ready_before_send", {31'd0, bus.in_ready}, 32'd1);
    bus.in_op = op; bus.in_cond = cond; bus.in_cmd = cmd; bus.in_imm = imm;
    bus.in_sl = sl; bus.in_rn = rn; bus.in_rd = rd; bus.in_src2 = src2;
    bus.in_imm24 = imm24;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    scramble();
    if (op != 2'b11) begin
      exp_t e;
      e.addr = exp_addr;
      e.data = word;
      e.cyc  = cyc + 1;
      sb.push_back(e);
      exp_addr = exp_addr + 2'd1;
      chk("err_quiet", {31'd0, bus.err}, 32'd0);
    end else begin
      chk("err_pulse", {31'd0, bus.err}, 32'd1);
    end
    @(posedge clk); #1;
    if (op == 2'b11) chk("err_clear", {31'd0, bus.err}, 32'd0);
    if (flush_w) bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    exp_addr = 2'd0;
`ifdef INSTR_ENCODER_ERRCNT_EN
    exp_errcnt = 8'd1;
`else
    exp_errcnt = 8'd0;
`endif
    reset_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.flush = 1'b0;
    scramble();
    #2;
    chk("rst_mem_we", {31'd0, bus.mem_we}, 32'd0);
    chk("rst_mem_addr", {30'd0, bus.mem_addr}, 32'd0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
    chk("rst_full", {31'd0, bus.full}, 32'd0);
    chk("rst_err", {31'd0, bus.err}, 32'd0);
    chk("rst_err_cnt", {24'd0, bus.err_cnt}, 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // ADD imm, CMP reg, illegal, LDR imm, branch: fills all four words.
    send(2'b00, 4'hE, 4'b0100, 1'b1, 1'b0, 4'd1, 4'd2, 12'h005, 24'h0, 32'hE2812005, 1'b0);
    send(2'b00, 4'hE, 4'b1010, 1'b0, 1'b0, 4'd3, 4'd7, 12'h004, 24'h0, 32'hE1530004, 1'b0);
    send(2'b11, 4'hE, 4'b0000, 1'b0, 1'b0, 4'd0, 4'd0, 12'h000, 24'h0, 32'h0, 1'b0);
    chk("err_cnt", {24'd0, bus.err_cnt}, {24'd0, exp_errcnt});
    send(2'b01, 4'hE, 4'b0000, 1'b1, 1'b1, 4'd0, 4'd1, 12'h008, 24'h0, 32'hE5901008, 1'b0);
    send(2'b10, 4'hE, 4'b0000, 1'b0, 1'b0, 4'd0, 4'd0, 12'h000, 24'hFFFFFE, 32'hEAFFFFFE, 1'b0);
    chk("full_set", {31'd0, bus.full}, 32'd1);
    chk("full_ready", {31'd0, bus.in_ready}, 32'd0);

    // Held request against a full region must not be accepted.
    bus.in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("full_hold_ready", {31'd0, bus.in_ready}, 32'd0);
    end
    bus.in_valid = 1'b0;

    @(negedge clk);
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    chk("flush_full", {31'd0, bus.full}, 32'd0);
    chk("flush_addr", {30'd0, bus.mem_addr}, 32'd0);
    exp_addr = 2'd0;

    // Write at 0, then a write at 1 with flush during WRITE, then back at 0.
    send(2'b00, 4'hE, 4'b0100, 1'b1, 1'b0, 4'd1, 4'd2, 12'h005, 24'h0, 32'hE2812005, 1'b0);
    send(2'b00, 4'hE, 4'b1010, 1'b0, 1'b0, 4'd3, 4'd7, 12'h004, 24'h0, 32'hE1530004, 1'b1);
    chk("flush_write_addr", {30'd0, bus.mem_addr}, 32'd0);
    exp_addr = 2'd0;
    send(2'b01, 4'hE, 4'b0000, 1'b1, 1'b1, 4'd0, 4'd1, 12'h008, 24'h0, 32'hE5901008, 1'b0);

    // Reset asserted mid-WRITE: mem_we must drop asynchronously, no write afterwards.
    @(negedge clk);
    bus.in_op = 2'b00; bus.in_cond = 4'hE; bus.in_cmd = 4'b0100; bus.in_imm = 1'b1;
    bus.in_sl = 1'b0; bus.in_rn = 4'd1; bus.in_rd = 4'd2; bus.in_src2 = 12'h005;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    chk("rstw_we_before", {31'd0, bus.mem_we}, 32'd1);
    reset_n = 1'b0;
    #1;
    chk("rstw_we_after", {31'd0, bus.mem_we}, 32'd0);
    chk("rstw_addr", {30'd0, bus.mem_addr}, 32'd0);
    chk("rstw_wdata", bus.mem_wdata, 32'd0);
    chk("rstw_err_cnt", {24'd0, bus.err_cnt}, 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("rstw_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("sb_drained", sb.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
